// File: rtl/dsp_sram_banks_pkg.sv
// ============================================================================
// dsp_sram_banks_pkg : shared word/address widths and frame FSM encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package dsp_sram_banks_pkg;

   localparam int REG_WORD_LEN  = 16;
   localparam int WORD_LEN      = REG_WORD_LEN;
   localparam int SRAM_ADDR_LEN = 8;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_FILL = 2'd1,
      FS_FULL = 2'd2
   } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/dsp_sram_1r1w.sv
// ============================================================================
// dsp_sram_1r1w : one SRAM bank, asynchronous read, synchronous write
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_sram_1r1w
   import dsp_sram_banks_pkg::*;
#(
   parameter int WORD_LEN = REG_WORD_LEN,
   parameter int ADDR_LEN = SRAM_ADDR_LEN
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [ADDR_LEN-1:0] waddr_i,
   input  logic [WORD_LEN-1:0] wdata_i,
   input  logic [ADDR_LEN-1:0] raddr_i,
   output logic [WORD_LEN-1:0] rdata_o
);

   logic [WORD_LEN-1:0] mem_q [2**ADDR_LEN];

   // Contents are deliberately never reset; a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/dsp_sram_banks.sv
// ============================================================================
// dsp_sram_banks : MEM-stage SRAM banks; bank 1 ingests framed samples,
//                  bank 2 is core read/write data RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_sram_banks
   import dsp_sram_banks_pkg::*;
#(
   parameter int WORD_LEN  = REG_WORD_LEN,
   parameter int ADDR_LEN  = SRAM_ADDR_LEN,
   parameter int FRAME_LEN = 128,
   parameter int DROP_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_LEN-1:0] read_addr_1,
   input  logic [ADDR_LEN-1:0] read_addr_2,
   output logic [WORD_LEN-1:0] read_data_1,
   output logic [WORD_LEN-1:0] read_data_2,
   input  logic [ADDR_LEN-1:0] write_addr_2,
   input  logic [WORD_LEN-1:0] write_data,
   input  logic                write_en,
   input  logic                capture_en,
   input  logic [WORD_LEN-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                frame_done,
   output logic [ADDR_LEN-1:0] frame_base,
   input  logic                frame_ack,
   output logic [DROP_W-1:0]   drop_count
);

   localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);
   localparam logic [DROP_W-1:0] DROP_MAX  = '1;

   frame_state_e        state_q, state_d;
   logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_LEN-1:0] start_ptr_q, start_ptr_d;
   logic [ADDR_LEN-1:0] frame_base_q, frame_base_d;
   logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
   logic                frame_done_q, frame_done_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic                accept;
   logic                completing;
   logic [CNT_W-1:0]    fill_inc;

   assign sample_ready = (state_q == FS_FILL);
   assign accept       = sample_valid && sample_ready;
   assign fill_inc     = fill_cnt_q + CNT_W'(1);
   assign completing   = accept && (fill_inc == FRAME_CNT);

   dsp_sram_1r1w #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN)) u_bank1 (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (sample_in),
      .raddr_i (read_addr_1),
      .rdata_o (read_data_1)
   );

   // Core writes are masked while reset is asserted.
   dsp_sram_1r1w #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN)) u_bank2 (
      .clk     (clk),
      .we_i    (write_en && !reset),
      .waddr_i (write_addr_2),
      .wdata_i (write_data),
      .raddr_i (read_addr_2),
      .rdata_o (read_data_2)
   );

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      start_ptr_d  = start_ptr_q;
      frame_base_d = frame_base_q;
      fill_cnt_d   = fill_cnt_q;
      frame_done_d = FALSE;
      drop_cnt_d   = drop_cnt_q;
      case (state_q)
         FS_IDLE: begin
            if (capture_en) begin
               state_d     = FS_FILL;
               start_ptr_d = wr_ptr_q;
               fill_cnt_d  = '0;
            end
         end
         FS_FILL: begin
            if (accept) begin
               wr_ptr_d   = wr_ptr_q + ADDR_LEN'(1);
               fill_cnt_d = fill_inc;
            end
            // A completing frame takes priority over capture_en falling.
            if (completing) begin
               state_d      = FS_FULL;
               frame_base_d = start_ptr_q;
               frame_done_d = TRUE;
            end else if (!capture_en) begin
               state_d = FS_IDLE;
            end
         end
         FS_FULL: begin
            if (sample_valid && (drop_cnt_q != DROP_MAX)) begin
               drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
            if (frame_ack) begin
               if (capture_en) begin
                  state_d     = FS_FILL;
                  start_ptr_d = wr_ptr_q;
                  fill_cnt_d  = '0;
               end else begin
                  state_d = FS_IDLE;
               end
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FS_IDLE;
         wr_ptr_q     <= '0;
         start_ptr_q  <= '0;
         frame_base_q <= '0;
         fill_cnt_q   <= '0;
         frame_done_q <= FALSE;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         start_ptr_q  <= start_ptr_d;
         frame_base_q <= frame_base_d;
         fill_cnt_q   <= fill_cnt_d;
         frame_done_q <= frame_done_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign frame_done = frame_done_q;
   assign frame_base = frame_base_q;
   assign drop_count = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_sram_banks.sv
// ============================================================================
// tb_dsp_sram_banks : directed bench for dsp_sram_banks with FRAME_LEN=4
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dsp_sram_banks;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  read_addr_1, read_addr_2, write_addr_2;
   logic [15:0] read_data_1, read_data_2, write_data, sample_in;
   logic        write_en, capture_en, sample_valid, sample_ready;
   logic        frame_done, frame_ack;
   logic [7:0]  frame_base, drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dsp_sram_banks #(.WORD_LEN(16), .ADDR_LEN(8), .FRAME_LEN(4), .DROP_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_addr_1  (read_addr_1),
      .read_addr_2  (read_addr_2),
      .read_data_1  (read_data_1),
      .read_data_2  (read_data_2),
      .write_addr_2 (write_addr_2),
      .write_data   (write_data),
      .write_en     (write_en),
      .capture_en   (capture_en),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .frame_done   (frame_done),
      .frame_base   (frame_base),
      .frame_ack    (frame_ack),
      .drop_count   (drop_count)
   );

   typedef struct {
      logic        we;
      logic [7:0]  waddr;
      logic [15:0] wdata;
      logic [7:0]  raddr;
      logic        chk;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streams four samples v0..v0+3 from FILL and checks the completion pulse.
   task automatic stream_frame(input logic [15:0] v0, input logic [7:0] exp_base,
                               input bit drop_last);
      for (int k = 0; k < 4; k++) begin
         sample_in    = v0 + 16'(k);
         sample_valid = 1'b1;
         if (drop_last && k == 3) capture_en = 1'b0;
         @(negedge clk);
         check("ready_fill", 32'(sample_ready), 1);
         step();
      end
      sample_valid = 1'b0;
      @(negedge clk);
      check("done_pulse", 32'(frame_done), 1);
      check("frame_base", 32'(frame_base), 32'(exp_base));
      check("ready_full", 32'(sample_ready), 0);
      step();
      @(negedge clk);
      check("done_clear", 32'(frame_done), 0);
      step();
   endtask

   task automatic ack(input logic cap);
      capture_en = cap;
      frame_ack  = 1'b1;
      step();
      frame_ack  = 1'b0;
   endtask

   task automatic check_bank1(input logic [7:0] base, input logic [15:0] v0);
      for (int i = 0; i < 4; i++) begin
         read_addr_1 = base + 8'(i);
         #1;
         check("bank1_data", 32'(read_data_1), 32'(v0 + 16'(i)));
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h05, 16'h0000, 8'h00, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 8'h10, 16'h1111, 8'h00, 1'b0, 16'h0000};
      vecs[2] = '{1'b1, 8'h05, 16'hBEEF, 8'h05, 1'b1, 16'h0000};
      vecs[3] = '{1'b1, 8'h10, 16'hCAFE, 8'h05, 1'b1, 16'hBEEF};
      vecs[4] = '{1'b0, 8'h00, 16'h0000, 8'h10, 1'b1, 16'hCAFE};
      vecs[5] = '{1'b1, 8'h10, 16'h5555, 8'h10, 1'b1, 16'hCAFE};
      vecs[6] = '{1'b0, 8'h00, 16'h0000, 8'h10, 1'b1, 16'h5555};
      vecs[7] = '{1'b0, 8'h00, 16'h0000, 8'h05, 1'b1, 16'hBEEF};

      reset = 1'b1;  read_addr_1 = '0; read_addr_2 = '0; write_addr_2 = '0;
      write_data = '0; write_en = 1'b0; capture_en = 1'b0; sample_in = '0;
      sample_valid = 1'b0; frame_ack = 1'b0;
      step();
      check("rst_ready", 32'(sample_ready), 0);
      check("rst_done",  32'(frame_done), 0);
      check("rst_base",  32'(frame_base), 0);
      check("rst_drop",  32'(drop_count), 0);
      reset = 1'b0;
      step();

      // Bank 2: same-cycle read returns the old word, new word next cycle.
      for (int i = 0; i < 8; i++) begin
         write_en = vecs[i].we; write_addr_2 = vecs[i].waddr;
         write_data = vecs[i].wdata; read_addr_2 = vecs[i].raddr;
         @(negedge clk);
         if (vecs[i].chk) check("bank2_vec", 32'(read_data_2), 32'(vecs[i].exp_rd));
         step();
      end
      write_en = 1'b0;

      // First frame of 4 from IDLE.
      capture_en = 1'b1;
      @(negedge clk);
      check("ready_idle", 32'(sample_ready), 0);
      step();
      stream_frame(16'h0001, 8'h00, 1'b0);
      check_bank1(8'h00, 16'h0001);

      // Drops while FULL saturate at 255.
      sample_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 9) check("drop_10", 32'(drop_count), 10);
      end
      check("drop_sat", 32'(drop_count), 255);
      sample_valid = 1'b0;
      ack(1'b1);
      stream_frame(16'h0005, 8'h04, 1'b0);

      // Walk the write pointer to 0xFC, then straddle the top of the bank.
      for (int f = 2; f < 64; f++) begin
         ack(1'b1);
         stream_frame(16'(f * 4 + 1), 8'(f * 4), 1'b0);
      end
      check_bank1(8'hFC, 16'd253);
      ack(1'b1);
      stream_frame(16'd257, 8'h00, 1'b0);
      check_bank1(8'h00, 16'd257);

      // Abort after two samples: back to IDLE, no frame_done.
      ack(1'b0);
      @(negedge clk);
      check("ready_ack_idle", 32'(sample_ready), 0);
      step();
      capture_en = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         sample_in = 16'h0077 + 16'(k); sample_valid = 1'b1;
         step();
      end
      capture_en = 1'b0; sample_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_ready", 32'(sample_ready), 0);
         check("abort_done",  32'(frame_done), 0);
         step();
      end

      // capture_en falls on the completing accept: completion wins.
      capture_en = 1'b1;
      step();
      stream_frame(16'h0100, 8'h06, 1'b1);
      check("drop_kept", 32'(drop_count), 255);

      // Asynchronous reset mid-FILL with a masked bank 2 write.
      ack(1'b1);
      sample_in = 16'h00AA; sample_valid = 1'b1;
      step();
      check("ready_prerst", 32'(sample_ready), 1);
      reset = 1'b1; write_en = 1'b1; write_addr_2 = 8'h05; write_data = 16'hDEAD;
      #1;
      check("arst_ready", 32'(sample_ready), 0);
      check("arst_done",  32'(frame_done), 0);
      check("arst_base",  32'(frame_base), 0);
      check("arst_drop",  32'(drop_count), 0);
      step();
      reset = 1'b0; write_en = 1'b0; capture_en = 1'b0; sample_valid = 1'b0;
      read_addr_2 = 8'h05;
      #1;
      check("bank2_after_rst", 32'(read_data_2), 32'h0000BEEF);
      step();
      capture_en = 1'b1;
      step();
      stream_frame(16'h0300, 8'h00, 1'b0);
      check_bank1(8'h00, 16'h0300);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dsp_sram_banks.md
Name: dsp_sram_banks

Overview:
- Memory-side responder for the DSP core's MEM stage. Owns the two data SRAM banks that the MEM stage addresses.
- Bank 1 is the receiver sample buffer: read-only to the core, filled by the front-end sample stream through a valid/ready handshake under a frame state machine.
- Bank 2 is general data RAM, read and written by the core.
- Sits between the front-end sample path and the MEM stage.

Parameters:
- WORD_LEN, 16, data word width (matches REG_WORD_LEN).
- ADDR_LEN, 8, bank address width; depth is 2^ADDR_LEN per bank.
- FRAME_LEN, 128, samples per capture frame (1..2^ADDR_LEN).
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_addr_1  in  ADDR_LEN  bank 1 read address from MEM stage.
- read_addr_2  in  ADDR_LEN  bank 2 read address from MEM stage.
- read_data_1  out  WORD_LEN  bank 1 read data.
- read_data_2  out  WORD_LEN  bank 2 read data.
- write_addr_2  in  ADDR_LEN  bank 2 write address.
- write_data  in  WORD_LEN  bank 2 write data.
- write_en  in  1  bank 2 write enable, active high.
- capture_en  in  1  arms frame capture.
- sample_in  in  WORD_LEN  front-end sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  block accepts the sample this cycle.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_base  out  ADDR_LEN  bank 1 start address of the last completed frame.
- frame_ack  in  1  core has consumed the frame; releases the buffer.
- drop_count  out  DROP_W  samples offered while not ready during FULL, saturating.

Behaviour:
- Reads are combinational (asynchronous) on both banks: read_data_n = bank_n[read_addr_n] in the same cycle. The MEM stage relies on zero-latency load data.
- Bank 2 write:
  - Commits at the rising clk edge when write_en=1.
  - A same-cycle read of the same address returns the old word; the new word is visible the next cycle.
  - write_en=1 during reset is ignored.
- Bank 1 ingest: a sample is accepted at a rising edge when sample_valid && sample_ready. On acceptance:
  - bank1[wr_ptr] <= sample_in.
  - wr_ptr increments modulo 2^ADDR_LEN and wraps from 2^ADDR_LEN-1 to 0.
  - fill_cnt increments.
- Ingest write vs. core read of the same bank 1 address in the same cycle: the read returns the old word.
- Frame FSM has three states: IDLE, FILL, FULL.
  - IDLE: sample_ready=0. If capture_en=1, go to FILL, set start_ptr <= wr_ptr, fill_cnt <= 0.
  - FILL: sample_ready=1. When the accepted sample makes fill_cnt reach FRAME_LEN:
    - frame_base <= start_ptr.
    - frame_done pulses on the next cycle (registered, exactly 1 cycle).
    - go to FULL.
  - FILL, capture_en dropped: if capture_en=0 and no frame is completing, go to IDLE and discard the partial frame. wr_ptr keeps its value.
  - FULL: sample_ready=0. Each cycle with sample_valid=1 increments drop_count, saturating at 2^DROP_W-1 with no wrap. frame_ack=1 goes to FILL if capture_en=1 (new start_ptr <= wr_ptr, fill_cnt <= 0), else to IDLE.
  - frame_ack outside FULL is ignored.
- Simultaneous events: frame completion and capture_en falling in the same cycle: completion wins (go to FULL, pulse frame_done).
- Wrap: frames are contiguous modulo depth. A frame may straddle address 2^ADDR_LEN-1 to 0, and frame_base marks its start.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, wr_ptr=0, fill_cnt=0, start_ptr=0, frame_base=0, frame_done=0, sample_ready=0, drop_count=0.
  - RAM contents are not reset.
  - read_data_n stays combinational on RAM contents, so it is undefined until written.
- drop_count clears only on reset.

Decomposition:
- Shared definitions file holds WORD_LEN/REG_WORD_LEN, SRAM_ADDR_LEN, TRUE/FALSE, and the frame FSM state encodings (FS_IDLE=2'd0, FS_FILL=2'd1, FS_FULL=2'd2).
- One sub-module, dsp_sram_1r1w: single bank, asynchronous read, synchronous write, parameterised WORD_LEN/ADDR_LEN. It is instantiated twice: bank 1 written by ingest, bank 2 written by the core.
- FSM, pointers and counters live in the top.

Test Plan:
- Bank 2 write/read: write_en=1, addr 8'h05, data 16'hBEEF for 1 cycle -> read_addr_2=8'h05 returns 16'hBEEF next cycle; same-cycle read returns prior 16'h0000 (preloaded).
- Frame capture, FRAME_LEN=4: capture_en=1, stream 16'h0001..16'h0004 with valid every cycle -> sample_ready high 4 accepts; frame_done single pulse; frame_base=0; bank1[0..3]=1..4; sample_ready then 0.
- Drops: in FULL, hold sample_valid=1 for 300 cycles with DROP_W=8 -> drop_count=255, no wrap; frame_ack=1 -> FILL, next frame_base=8'h04.
- Wrap: preset wr_ptr near end by capturing 63 frames of 4, then one more -> frame_base=8'hFC, samples at FC..FF, wr_ptr=0.
- Abort and reset: drop capture_en after 2 samples -> IDLE, no frame_done. Assert reset mid-FILL -> all outputs at reset values immediately (asynchronous), bank 2 data written earlier still readable.
- Completion vs. abort: capture_en falls in the same cycle as the 4th accept -> FULL and frame_done asserted.
